// File: rtl/pipelined_barrel_shifter.sv
// Pipelined WIDTH-bit shift/rotate unit (LSL/LSR/ASR/ROL), one 2:1 mux stage per
// shift-amount bit, with a single global stall enable driven by output backpressure.

module pbs_stage #(
  parameter int WIDTH = 8,
  parameter int SW    = 3,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SW-1:0]    i_shamt,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_data,
  output logic [SW-1:0]    o_shamt,
  output logic [1:0]       o_mode
);
  localparam int SH = 1 << K;

  logic [WIDTH-1:0] w_shf;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_shamt;
  logic [1:0]       r_mode;

  // ASR uses the current MSB as fill; earlier stages preserve the original sign
  always_comb begin
    w_shf = i_data;
    if (i_shamt[K]) begin
      case (i_mode)
        2'b00:   w_shf = i_data << SH;
        2'b01:   w_shf = i_data >> SH;
        2'b10:   w_shf = $signed(i_data) >>> SH;
        default: w_shf = (i_data << SH) | (i_data >> (WIDTH - SH));
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_shamt <= '0;
      r_mode  <= '0;
    end else if (i_en) begin
      r_data  <= w_shf;
      r_shamt <= i_shamt;
      r_mode  <= i_mode;
    end
  end

  assign o_data  = r_data;
  assign o_shamt = r_shamt;
  assign o_mode  = r_mode;
endmodule

module pipelined_barrel_shifter #(
  parameter int  WIDTH = 8,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  logic                         w_adv;
  logic [SW-1:0]                vld_pipe;
  logic [SW-1:0][WIDTH-1:0]     w_dat;
  logic [SW-1:0][SW-1:0]        w_sa;
  logic [SW-1:0][1:0]           w_md;
  logic                         w_unused;

  // Whole pipe moves together; a stall anywhere freezes every stage
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      vld_pipe <= '0;
    else if (w_adv) vld_pipe <= {vld_pipe[SW-2:0], in_valid};
  end

  for (genvar k = 0; k < SW; k++) begin : g_stg
    logic [WIDTH-1:0] w_di;
    logic [SW-1:0]    w_si;
    logic [1:0]       w_mi;
    if (k == 0) begin : g_first
      assign w_di = in_data;
      assign w_si = in_shamt;
      assign w_mi = in_mode;
    end else begin : g_rest
      assign w_di = w_dat[k-1];
      assign w_si = w_sa[k-1];
      assign w_mi = w_md[k-1];
    end
    pbs_stage #(.WIDTH(WIDTH), .SW(SW), .K(k)) u_stg (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_adv),
      .i_data (w_di),
      .i_shamt(w_si),
      .i_mode (w_mi),
      .o_data (w_dat[k]),
      .o_shamt(w_sa[k]),
      .o_mode (w_md[k])
    );
  end

  assign out_valid = vld_pipe[SW-1];
  assign out_data  = w_dat[SW-1];
  assign out_zero  = ~|out_data;

  // Final-stage shamt/mode have no consumer downstream
  assign w_unused = ^{w_sa[SW-1], w_md[SW-1]};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomized + directed bench for pipelined_barrel_shifter (WIDTH=8) with a
// queue scoreboard fed by an arithmetic reference model.

module tb_pipelined_barrel_shifter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_shamt;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_zero;

  int n_tot = 0;
  int n_bad = 0;
  int n_out = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] held;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on a 32-bit word
  function automatic logic [W-1:0] ref_f(input logic [W-1:0] d, input int s, input logic [1:0] m);
    int unsigned x;
    int unsigned r;
    x = d;
    case (m)
      2'd0: r = x << s;
      2'd1: r = x >> s;
      2'd2: r = (d[W-1] ? (x | 32'hFFFF_FF00) : x) >> s;
      default: r = (x << s) | (x >> (W - s));
    endcase
    return r[W-1:0];
  endfunction

  // Scoreboard: every accepted op must emerge once, in order, correct; stalls hold data
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(ref_f(in_data, int'(in_shamt), in_mode));
      if (stall_prev && out_valid) chk("stall_hold", out_data, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("sb_data", out_data, e);
          chk("sb_zero", out_zero, (e == 0));
          n_out++;
        end
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [2:0] s, input logic [1:0] m);
    in_valid = v;
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] d, input logic [2:0] s,
                         input logic [1:0] m, input logic [W-1:0] e);
    int acc;
    bit got;
    @(posedge clk); #1;
    drive(1'b1, d, s, m);
    out_ready = 1'b1;
    @(negedge clk);
    acc = cyc;
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    chk({tag, "_lat"}, got ? (cyc - acc) : -1, 3);
    chk({tag, "_data"}, out_data, e);
    chk({tag, "_zero"}, out_zero, (e == 0));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    logic [W-1:0] e0;
    logic [W-1:0] bp_d[5];
    logic [2:0]   bp_s[5];
    logic [1:0]   bp_m[5];
    int qi;
    int out0;
    logic acc_last;

    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_zero", out_zero, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Modes on 0x96 by 3
    run_one("lsl", 8'h96, 3'd3, 2'd0, 8'hB0);
    run_one("lsr", 8'h96, 3'd3, 2'd1, 8'h12);
    run_one("asr", 8'h96, 3'd3, 2'd2, 8'hF2);
    run_one("rol", 8'h96, 3'd3, 2'd3, 8'hB4);
    // Boundaries
    run_one("rol0", 8'h5A, 3'd0, 2'd3, 8'h5A);
    run_one("lsr7", 8'h80, 3'd7, 2'd1, 8'h01);
    run_one("asr7", 8'h80, 3'd7, 2'd2, 8'hFF);
    run_one("rol7", 8'h01, 3'd7, 2'd3, 8'h80);
    run_one("lsl_zero", 8'h80, 3'd1, 2'd0, 8'h00);
    idle(2);

    // Streaming: 8 back-to-back LSL of 0x01
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (i < 8) drive(1'b1, 8'h01, 3'(i), 2'd0);
      else       in_valid = 1'b0;
      @(negedge clk);
      if (i < 8) chk("stream_rdy", in_ready, 1);
      if (i >= 3 && i < 11) begin
        chk("stream_vld", out_valid, 1);
        chk("stream_data", out_data, ref_f(8'h01, i - 3, 2'd0));
      end
    end
    idle(2);

    // Backpressure: 5 ops, out_ready low for 4 cycles once the first result shows
    for (int k = 0; k < 5; k++) begin
      bp_d[k] = 8'($urandom);
      bp_s[k] = 3'($urandom);
      bp_m[k] = 2'($urandom);
    end
    e0 = ref_f(bp_d[0], int'(bp_s[0]), bp_m[0]);
    qi = 0;
    out0 = n_out;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      out_ready = !(i >= 3 && i <= 6);
      if (qi < 5) drive(1'b1, bp_d[qi], bp_s[qi], bp_m[qi]);
      else        in_valid = 1'b0;
      @(negedge clk);
      if (i >= 3 && i <= 6) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_vld", out_valid, 1);
        chk("bp_hold", out_data, e0);
      end
      if (in_valid && in_ready) qi++;
    end
    chk("bp_count", n_out - out0, 5);
    idle(2);

    // Bubble: op, gap, op
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (i == 0)      drive(1'b1, 8'h3C, 3'd2, 2'd3);
      else if (i == 2) drive(1'b1, 8'hC3, 3'd1, 2'd2);
      else             in_valid = 1'b0;
      @(negedge clk);
      if (i == 3) begin chk("bub_v0", out_valid, 1); chk("bub_d0", out_data, 8'hF0); end
      if (i == 4) chk("bub_v1", out_valid, 0);
      if (i == 5) begin chk("bub_v2", out_valid, 1); chk("bub_d2", out_data, 8'hE1); end
    end
    idle(2);

    // Reset mid-flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(1'b1, 8'(8'h11 * (i + 1)), 3'(i + 1), 2'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_vld", out_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_vld", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_zero", out_zero, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    run_one("post_rst", 8'h0F, 3'd4, 2'd0, 8'hF0);
    idle(2);

    // Random traffic with random backpressure and bubbles
    acc_last = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!in_valid || acc_last)
        drive(($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 2'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_last = in_valid && in_ready;
    end
    idle(8);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined shift/rotate unit. Successor to the team's fixed 4-bit combinational left shifter built from 2:1 mux stages.
- Generalised to WIDTH bits, with four modes: logical left, logical right, arithmetic right, rotate left.
- One register per mux stage, so it sits on the datapath at one result per clock.
- Valid/ready handshake on input and output, with full backpressure.

Parameters:
- WIDTH, 8, data width in bits. Power of two, at least 4.
- SW, $clog2(WIDTH), shift-amount width and pipeline depth. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  block accepts the operation this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SW  shift amount, 0..WIDTH-1
- in_mode  input  2  operation select: 00 LSL, 01 LSR, 10 ASR, 11 ROL
- out_valid  output  1  result is presented
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH  shifted or rotated result
- out_zero  output  1  out_data equals zero

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port reset. All state is clocked on the rising edge of clk.
- Reset values:
  - every stage valid bit is 0, every data/shamt/mode register is 0;
  - hence out_valid=0, out_data=0, out_zero=1.
  - in_ready may be 1 during reset; in_valid is ignored while reset is high.
- Pipeline structure: SW stages, numbered 0..SW-1. Each stage holds valid, data, shamt, mode.
- Stage k operation: if shamt bit k is 1, the stage shifts its input by 2^k in the mode's direction; otherwise it passes the input unchanged. The result registers into stage k.
- Fill rules per mode:
  - LSL: vacated low bits filled with 0.
  - LSR: vacated high bits filled with 0.
  - ASR: vacated high bits filled with the operand's original MSB. The sign is carried with the operand; each stage uses its current data MSB, which equals the original sign because ASR preserves it.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- Output: out_data, out_valid and the registered mode come from stage SW-1. out_zero is combinational from out_data.
- Stall enable: advance = out_ready | ~out_valid. This is a single global enable; no per-stage bubble collapsing.
  - When advance=1, every stage loads from its predecessor. Stage 0 loads {in_valid, in_data, in_shamt, in_mode}.
  - When advance=0, all stages hold.
- in_ready = advance. An operation transfers on in_valid & in_ready; a result transfers on out_valid & out_ready.
- Latency: exactly SW cycles from input transfer to out_valid, with no stalls. WIDTH=8 gives 3 cycles.
- Throughput: one operation per cycle when out_ready is held high.
- Stall behaviour: while out_valid=1 and out_ready=0, out_data, out_zero and out_valid stay stable. No result is lost or duplicated.
- Bubbles: an in_valid=0 cycle while advancing inserts a bubble, i.e. a stage with valid=0. Bubbles propagate and do not stall.
- Ordering: results leave in acceptance order.
- shamt=0 in any mode: out_data = in_data.
- in_shamt is masked to SW bits by construction, so no out-of-range case exists.
- Reset asserted mid-operation: all in-flight operations are discarded immediately, asynchronously. out_valid drops to 0 without waiting for a clock edge.
- After reset deasserts, the first accepted operation appears after SW cycles.
- Simultaneous input and output transfer in the same cycle is legal. The pipeline shifts by one stage.

Test Plan:
- Modes with WIDTH=8, in_data=0x96, shamt=3, out_ready=1:
  - LSL -> 0xB0, LSR -> 0x12, ASR -> 0xF2, ROL -> 0xB4.
  - Each result appears exactly 3 cycles after acceptance, out_zero=0.
- Boundaries:
  - shamt=0, mode ROL, 0x5A -> 0x5A.
  - shamt=7, LSR 0x80 -> 0x01.
  - shamt=7, ASR 0x80 -> 0xFF.
  - shamt=7, ROL 0x01 -> 0x80.
  - LSL 0x80 by 1 -> 0x00 with out_zero=1.
- Streaming: 8 back-to-back LSL ops of 0x01 with shamt=0..7, out_ready=1 -> results 0x01,0x02,...,0x80 on 8 consecutive cycles starting at cycle 3. in_ready stays 1 throughout.
- Backpressure: stream 5 ops, then drop out_ready for 4 cycles once out_valid=1.
  - in_ready=0 during the stall, out_data held stable.
  - On release, all 5 results arrive in order with none dropped or repeated.
- Bubbles: accept, skip a cycle (in_valid=0), accept -> out_valid pattern 1,0,1 with correct data.
- Reset mid-flight: accept 3 ops, assert reset between clock edges.
  - out_valid=0 and out_data=0 immediately.
  - After release, no stale results appear.
  - A new op 0x0F LSL 4 -> 0xF0 after 3 cycles.
